// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch
// requester (IF stage) and the data requester (MEM stage, lw/sw). Each access
// is sequenced through a req/ack handshake to a variable-latency memory. Read
// data goes back to the requester that won, and per-stage stall signals go
// back to the hazard logic. A watchdog abandons accesses the memory never
// acknowledges. Misaligned data accesses are rejected without touching
// memory. Both errors raise sticky flags.
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  busy cycles without mem_ack before an access is abandoned (>= 1)
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   if_req/if_addr      fetch request (held until if_valid) and byte address
//   if_rdata/if_valid   fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata
//                       data request (held until d_valid), store flag,
//                       byte address and store data
//   d_rdata/d_valid     load data and its one-cycle completion pulse
//   stall_if/stall_mem  requester is waiting (req high, valid not yet seen)
//   mem_req/mem_we/mem_addr/mem_wdata
//                       registered memory command, stable while busy
//   mem_rdata/mem_ack   memory read data, sampled with the one-cycle ack
//   err_timeout         sticky: an access was abandoned by the watchdog
//   err_align           sticky: a data access had d_addr[1:0] != 0
//------------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          err_timeout,
   output logic          err_align
);

   // Watchdog is wide enough to hold TIMEOUT itself.
   localparam int             WDW     = $clog2(TIMEOUT + 1);
   // Value the watchdog holds during the last allowed busy cycle.
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t          state_q,       state_d;
   logic [WDW-1:0]  wd_q,          wd_d;
   logic            mem_req_q,     mem_req_d;
   logic            mem_we_q,      mem_we_d;
   logic [AW-1:0]   mem_addr_q,    mem_addr_d;
   logic [DW-1:0]   mem_wdata_q,   mem_wdata_d;
   logic [DW-1:0]   if_rdata_q,    if_rdata_d;
   logic            if_valid_q,    if_valid_d;
   logic [DW-1:0]   d_rdata_q,     d_rdata_d;
   logic            d_valid_q,     d_valid_d;
   logic            err_timeout_q, err_timeout_d;
   logic            err_align_q,   err_align_d;

   logic            d_cand;
   logic            i_cand;
   logic            d_misaligned;
   logic            wd_expired;
   logic            busy_done;
   logic [DW-1:0]   ret_data;

   // A requester whose valid is pulsing this cycle still has its req high,
   // but that req belongs to the access just completed, so it must not win.
   assign d_cand       = d_req  & ~d_valid_q;
   assign i_cand       = if_req & ~if_valid_q;
   assign d_misaligned = (d_addr[1:0] != 2'b00);
   assign wd_expired   = (wd_q == WD_LAST);
   // Ack takes precedence over the watchdog when both land on the same edge.
   assign busy_done    = (state_q != IDLE) & (mem_ack | wd_expired);
   // Abandoned accesses return zero instead of whatever is on the bus.
   assign ret_data     = mem_ack ? mem_rdata : '0;

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic: fixed priority data > fetch, no preemption
   //---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (d_cand) begin
               // Misaligned data is answered directly from IDLE.
               state_d = d_misaligned ? IDLE : BUSY_D;
            end else if (i_cand) begin
               state_d = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (busy_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Output / datapath next-value logic
   //---------------------------------------------------------------------------
   always_comb begin
      wd_d          = wd_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_rdata_d    = if_rdata_q;
      if_valid_d    = 1'b0;
      d_rdata_d     = d_rdata_q;
      d_valid_d     = 1'b0;
      err_timeout_d = err_timeout_q;
      err_align_d   = err_align_q;

      case (state_q)
         IDLE: begin
            wd_d = '0;
            if (d_cand) begin
               if (d_misaligned) begin
                  d_valid_d   = 1'b1;
                  d_rdata_d   = '0;
                  err_align_d = 1'b1;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end
            end else if (i_cand) begin
               // Fetch address low bits go to memory unchecked.
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr;
            end
         end

         BUSY_I, BUSY_D: begin
            if (busy_done) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               wd_d      = '0;
               if (!mem_ack) begin
                  err_timeout_d = 1'b1;
               end
               if (state_q == BUSY_I) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = ret_data;
               end else begin
                  d_valid_d = 1'b1;
                  // A completed store leaves the previous load data in place.
                  if (!(mem_ack && mem_we_q)) begin
                     d_rdata_d = ret_data;
                  end
               end
            end else begin
               wd_d = wd_q + WD_ONE;
            end
         end

         default: ;
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_q          <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         if_valid_q    <= 1'b0;
         d_rdata_q     <= '0;
         d_valid_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         err_align_q   <= 1'b0;
      end else begin
         wd_q          <= wd_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_rdata_q    <= if_rdata_d;
         if_valid_q    <= if_valid_d;
         d_rdata_q     <= d_rdata_d;
         d_valid_q     <= d_valid_d;
         err_timeout_q <= err_timeout_d;
         err_align_q   <= err_align_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign if_rdata    = if_rdata_q;
   assign if_valid    = if_valid_q;
   assign d_rdata     = d_rdata_q;
   assign d_valid     = d_valid_q;
   assign err_timeout = err_timeout_q;
   assign err_align   = err_align_q;

   // Stalls follow the registered valids so the hazard logic sees them
   // drop in the same cycle the completion pulse appears.
   assign stall_if  = if_req & ~if_valid_q;
   assign stall_mem = d_req  & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two random requesters (fetch and data) run concurrently against a bench
// memory responder with random latency. Addresses with bits [11:8] == 4'hF
// are never acknowledged, exercising the watchdog. Expected completions are
// queued by the requesters when they issue; a negedge monitor pops and
// compares whenever a valid pulses, and also checks arbitration, command
// stability, busy length, stalls, sticky flags and reset values. A final
// directed phase resets the block in the middle of a fetch.
//------------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_valid;
   logic          stall_if;
   logic          stall_mem;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          err_timeout;
   logic          err_align;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_valid   (if_valid),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_valid    (d_valid),
      .stall_if   (stall_if),
      .stall_mem  (stall_mem),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .err_timeout(err_timeout),
      .err_align  (err_align)
   );

   typedef struct {
      logic [31:0] rdata;
      bit          tmo;
      bit          mis;
   } exp_t;

   int          errors = 0;
   int          checks = 0;
   exp_t        exp_i[$];
   exp_t        exp_d[$];
   logic [31:0] ref_mem [logic [31:0]];   // reference view of stored data
   logic [31:0] bmem    [logic [31:0]];   // responder's memory contents
   bit          hold_ack  = 1'b0;
   int          resp_lat  = 1;
   bit          resp_dead = 1'b0;

   // Contents of never-written locations.
   function automatic logic [31:0] fmem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h8C080004;
   endfunction

   function automatic bit is_dead(input logic [31:0] a);
      return a[11:8] == 4'hF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, expv);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic wait_valid(input bit is_d, input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if ((is_d && d_valid) || (!is_d && if_valid)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL %s: valid not seen within 100 cycles", name);
         finish_run();
      end
   endtask

   //---------------------------------------------------------------------------
   // Data requester: loads, stores, misaligned and never-acked loads
   //---------------------------------------------------------------------------
   task automatic data_drv();
      exp_t        e;
      logic [31:0] a;
      logic [31:0] last_d;
      int          r;
      last_d = '0;
      for (int n = 0; n < 80; n++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         r       = int'($urandom_range(0, 9));
         e.tmo   = 1'b0;
         e.mis   = 1'b0;
         d_we    = 1'b0;
         d_wdata = $urandom;
         if (r == 0) begin
            a       = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
            e.mis   = 1'b1;
            e.rdata = '0;
         end else if (r == 1) begin
            a       = 32'h0F00 + 32'(4 * $urandom_range(0, 63));
            e.tmo   = 1'b1;
            e.rdata = '0;
         end else if (r <= 5) begin
            a          = 32'(4 * $urandom_range(0, 63));
            d_we       = 1'b1;
            ref_mem[a] = d_wdata;
            e.rdata    = last_d;
         end else begin
            a       = 32'(4 * $urandom_range(0, 63));
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : fmem(a);
         end
         last_d = e.rdata;
         d_addr = a;
         exp_d.push_back(e);
         d_req = 1'b1;
         wait_valid(1'b1, "d_handshake");
         @(posedge clk);
         #1;
         d_req = 1'b0;
      end
   endtask

   //---------------------------------------------------------------------------
   // Fetch requester: any low address bits, occasionally never acked
   //---------------------------------------------------------------------------
   task automatic fetch_drv();
      exp_t        e;
      logic [31:0] a;
      for (int n = 0; n < 80; n++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         e.mis = 1'b0;
         if ($urandom_range(0, 11) == 0) begin
            a       = 32'h1F00 + 32'($urandom_range(0, 255));
            e.tmo   = 1'b1;
            e.rdata = '0;
         end else begin
            a       = 32'h1000 + 32'($urandom_range(0, 32'hEFF));
            e.tmo   = 1'b0;
            e.rdata = fmem(a);
         end
         if_addr = a;
         exp_i.push_back(e);
         if_req = 1'b1;
         wait_valid(1'b0, "if_handshake");
         @(posedge clk);
         #1;
         if_req = 1'b0;
      end
   endtask

   //---------------------------------------------------------------------------
   // Reset in the middle of a fetch; the held request must be reissued.
   //---------------------------------------------------------------------------
   task automatic reset_test();
      exp_t e;
      bit   seen;
      hold_ack = 1'b1;
      e.rdata  = fmem(32'h0000_1234);
      e.tmo    = 1'b0;
      e.mis    = 1'b0;
      if_addr  = 32'h0000_1234;
      exp_i.push_back(e);
      if_req = 1'b1;
      seen   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_req) begin
            seen = 1'b1;
            break;
         end
      end
      chk1("rst_test_issue", mem_req, 1'b1);
      if (!seen) finish_run();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset    = 1'b1;
      hold_ack = 1'b0;
      wait_valid(1'b0, "if_after_reset");
      @(posedge clk);
      #1;
      if_req = 1'b0;
   endtask

   //---------------------------------------------------------------------------
   // Memory responder: random latency, dead region never acked, stray acks
   // after an access has ended.
   //---------------------------------------------------------------------------
   initial begin : responder
      int rcnt;
      rcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (mem_req) begin
            if (rcnt == 0) begin
               resp_lat  = int'($urandom_range(1, 4));
               resp_dead = is_dead(mem_addr);
            end
            rcnt++;
            if (!resp_dead && !hold_ack && rcnt == resp_lat) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  bmem[mem_addr] = mem_wdata;
               end else begin
                  mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : fmem(mem_addr);
               end
            end
         end else begin
            if (rcnt != 0 && (resp_dead || $urandom_range(0, 2) == 0)) begin
               mem_ack = 1'b1;
            end
            rcnt = 0;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Monitor / scoreboard
   //---------------------------------------------------------------------------
   initial begin : monitor
      logic        rst_snap, mreq_prev;
      logic        s_dal, s_dmis, s_i, s_dwe;
      logic [31:0] s_daddr, s_dwdata, s_iaddr;
      logic [31:0] p_addr, p_wdata, prev_i, prev_d;
      logic        p_we;
      bit          exp_et, exp_ea;
      int          mhi;
      exp_t        e;
      rst_snap = 1'b0; mreq_prev = 1'b0;
      s_dal = 1'b0; s_dmis = 1'b0; s_i = 1'b0; s_dwe = 1'b0;
      s_daddr = '0; s_dwdata = '0; s_iaddr = '0;
      p_addr = '0; p_wdata = '0; p_we = 1'b0; prev_i = '0; prev_d = '0;
      exp_et = 1'b0; exp_ea = 1'b0; mhi = 0;
      forever begin
         @(negedge clk);
         if (!rst_snap) begin
            chk1("rst_mem_req", mem_req, 1'b0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chk("rst_mem_addr", mem_addr, '0);
            chk1("rst_if_valid", if_valid, 1'b0);
            chk1("rst_d_valid", d_valid, 1'b0);
            chk("rst_if_rdata", if_rdata, '0);
            chk("rst_d_rdata", d_rdata, '0);
            chk1("rst_err_timeout", err_timeout, 1'b0);
            chk1("rst_err_align", err_align, 1'b0);
            exp_et = 1'b0; exp_ea = 1'b0;
            prev_i = '0; prev_d = '0; mhi = 0;
         end else begin
            chk1("stall_if", stall_if, if_req && !if_valid);
            chk1("stall_mem", stall_mem, d_req && !d_valid);

            if (if_valid) begin
               if (exp_i.size() == 0) begin
                  chk1("if_valid_unexpected", if_valid, 1'b0);
               end else begin
                  e = exp_i.pop_front();
                  chk("if_rdata", if_rdata, e.rdata);
                  if (e.tmo) exp_et = 1'b1;
                  prev_i = e.rdata;
               end
            end else begin
               chk("if_rdata_hold", if_rdata, prev_i);
            end

            if (d_valid) begin
               if (exp_d.size() == 0) begin
                  chk1("d_valid_unexpected", d_valid, 1'b0);
               end else begin
                  e = exp_d.pop_front();
                  chk("d_rdata", d_rdata, e.rdata);
                  if (e.tmo) exp_et = 1'b1;
                  if (e.mis) exp_ea = 1'b1;
                  prev_d = e.rdata;
               end
            end else begin
               chk("d_rdata_hold", d_rdata, prev_d);
            end

            chk1("err_timeout", err_timeout, exp_et);
            chk1("err_align", err_align, exp_ea);

            // Arbitration: judged on the inputs the issuing edge sampled.
            if (mem_req && !mreq_prev) begin
               if (s_dmis) begin
                  chk1("no_issue_on_misalign", mem_req, 1'b0);
               end else if (s_dal) begin
                  chk("grant_d_addr", mem_addr, s_daddr);
                  chk1("grant_d_we", mem_we, s_dwe);
                  if (s_dwe) chk("grant_d_wdata", mem_wdata, s_dwdata);
               end else if (s_i) begin
                  chk("grant_i_addr", mem_addr, s_iaddr);
                  chk1("grant_i_we", mem_we, 1'b0);
               end else begin
                  chk1("spurious_issue", mem_req, 1'b0);
               end
            end else if (!mreq_prev && (s_dal || (s_i && !s_dmis))) begin
               chk1("missed_issue", mem_req, 1'b1);
            end

            if (mem_req && mreq_prev) begin
               chk("hold_mem_addr", mem_addr, p_addr);
               chk1("hold_mem_we", mem_we, p_we);
               chk("hold_mem_wdata", mem_wdata, p_wdata);
            end

            if (mem_req) begin
               mhi++;
            end else if (mreq_prev) begin
               chk("busy_cycles", 32'(mhi), resp_dead ? 32'(TIMEOUT) : 32'(resp_lat));
               mhi = 0;
            end
         end

         rst_snap  = reset;
         mreq_prev = mem_req;
         p_addr    = mem_addr;
         p_we      = mem_we;
         p_wdata   = mem_wdata;
         s_dal     = d_req && !d_valid && (d_addr[1:0] == 2'b00);
         s_dmis    = d_req && !d_valid && (d_addr[1:0] != 2'b00);
         s_i       = if_req && !if_valid;
         s_dwe     = d_we;
         s_daddr   = d_addr;
         s_dwdata  = d_wdata;
         s_iaddr   = if_addr;
      end
   end

   //---------------------------------------------------------------------------
   // Main sequence
   //---------------------------------------------------------------------------
   initial begin : main
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      fork
         data_drv();
         fetch_drv();
      join
      reset_test();
      repeat (20) @(posedge clk);
      chk("exp_i_drained", 32'(exp_i.size()), 32'd0);
      chk("exp_d_drained", 32'(exp_d.size()), 32'd0);
      finish_run();
   end

   initial begin : global_bound
      #300000;
      errors++;
      checks++;
      $display("FAIL global_timeout: run did not complete within 30000 cycles");
      finish_run();
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage, lw/sw).
- Sequences each access through a req/ack handshake to a variable-latency memory.
- Returns read data to the winning requester and drives per-stage stall signals back to the hazard logic.
- Watchdog timeout and misalignment detection with sticky error flags.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, max cycles in a busy state without mem_ack before the access is abandoned (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  AW  fetch byte address.
- if_rdata  out  DW  fetched instruction; valid while if_valid is high.
- if_valid  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid while d_valid is high.
- d_valid  out  1  one-cycle completion pulse for data.
- stall_if  out  1  if_req & ~if_valid (combinational).
- stall_mem  out  1  d_req & ~d_valid (combinational).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  AW  memory address, registered.
- mem_wdata  out  DW  memory write data, registered.
- mem_rdata  in  DW  memory read data, sampled when mem_ack is high.
- mem_ack  in  1  one-cycle completion from memory.
- err_timeout  out  1  sticky; set on watchdog expiry.
- err_align  out  1  sticky; set on misaligned data access.

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE; mem_req, mem_we, if_valid, d_valid, err_timeout, err_align = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; watchdog = 0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, fixed priority data > fetch:
  - d_req with d_addr[1:0]!=0: no memory access; next cycle d_valid=1, d_rdata=0, err_align set; stay IDLE.
  - d_req aligned: latch d_addr, d_we, d_wdata onto mem_*; set mem_req=1; go to BUSY_D.
  - else if_req: latch if_addr; mem_we=0; set mem_req=1; go to BUSY_I. if_addr[1:0] is passed through unchecked.
  - A requester whose valid pulses in this cycle is ignored for arbitration in this cycle.
- BUSY_x:
  - mem_req, mem_we, mem_addr, mem_wdata held stable.
  - Watchdog increments each cycle. Width is clog2(TIMEOUT+1).
  - On mem_ack: next edge drops mem_req, pulses x_valid, and sets x_rdata=mem_rdata for a load or fetch. For a store, d_rdata keeps its previous value. Watchdog clears; state returns to IDLE.
  - If watchdog reaches TIMEOUT with no ack: same exit, but x_rdata=0 and err_timeout set.
- Latency: request sampled in IDLE at edge t gives mem_req high after t. Ack at edge k gives valid high after k. The next access can issue at edge k+1. Back-to-back access spacing is (memory latency + 1) cycles.
- No preemption: a d_req arriving during BUSY_I waits for the fetch to complete, then wins next arbitration.
- Simultaneous if_req and d_req in IDLE: data is granted; fetch is served on the next arbitration.
- mem_ack seen while in IDLE (late or stray) is ignored and does not change the rdata outputs.
- Reset mid-access: state returns to IDLE and mem_req drops on that edge. The memory must tolerate an abandoned request.
- Error flags clear only on reset.
- The requester deasserting its req before valid is illegal; behaviour in that case is unspecified.

Test Plan:
- Fetch only: if_req=1, if_addr=0x40, ack 2 cycles after mem_req with mem_rdata=0x8C080004. Expect mem_req for 2 cycles, if_valid pulse, if_rdata=0x8C080004, stall_if high until the pulse.
- Contention: if_req and d_req (load, 0x100) raised in the same cycle, ack latency 1. Expect data serviced first (mem_addr=0x100, mem_we=0), then fetch issued one cycle after d_valid; stall_if held throughout.
- Store: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF. Expect mem_we=1 with stable addr/wdata until ack, d_valid pulse, d_rdata unchanged.
- Timeout: d_req load, no ack. Expect after exactly 16 busy cycles: d_valid=1, d_rdata=0, err_timeout=1. A later stray mem_ack is ignored.
- Misaligned: d_req with d_addr=0x102. Expect no mem_req, d_valid the next cycle, err_align=1.
- Reset mid-access: reset=0 during BUSY_I. Expect mem_req=0, all valids=0, flags=0 after that edge; a pending if_req is reissued after reset is released.
